frame_controller: RTL and testbench

Sequencing and arbitration block for the 8x16 LED matrix datapath. It owns a double-buffered 128-bit frame store and arbitrates single-pixel writes from two requesters (game logic and overlay) into the back buffer. It commits the back buffer to the front buffer only on a scan-frame boundary, so the matrix never shows a half-updated frame. It also produces the row-scan enable and row index that pace the matrix scanner, which consumes the front buffer as `pixelReg`.

---
 rtl/frame_controller_if.sv | 34 +++
 rtl/frame_controller.sv | 125 ++++++++++++
 tb/tb_frame_controller.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_controller_if.sv
// Requester and swap handshake bundle for frame_controller.
// master: requester/sequencer side (drives valids, pixel data, clr, swap_req).
// slave : frame_controller side (drives readies and swap_ack).
interface frame_controller_if;
    logic       req0_valid;
    logic       req0_ready;
    logic [2:0] req0_row;
    logic [3:0] req0_col;
    logic       req0_val;

    logic       req1_valid;
    logic       req1_ready;
    logic [2:0] req1_row;
    logic [3:0] req1_col;
    logic       req1_val;

    logic       clr;
    logic       swap_req;
    logic       swap_ack;

    modport master (
        output req0_valid, req0_row, req0_col, req0_val,
        output req1_valid, req1_row, req1_col, req1_val,
        output clr, swap_req,
        input  req0_ready, req1_ready, swap_ack
    );

    modport slave (
        input  req0_valid, req0_row, req0_col, req0_val,
        input  req1_valid, req1_row, req1_col, req1_val,
        input  clr, swap_req,
        output req0_ready, req1_ready, swap_ack
    );
endinterface

// File: rtl/frame_controller.sv
// Double-buffered 8x16 frame store with two-requester pixel-write arbitration,
// frame-aligned back->front commit, and row-scan pacing for the matrix scanner.
// Ports:
//   clk, aclr    : clock, synchronous active-high reset
//   bus (slave)  : requester 0/1 write handshakes, clr, swap_req/swap_ack
//   pixelReg     : front buffer, pixel (r,c) at bit r*16+c
//   scan_en      : one-cycle row-step pulse every SCAN_DIV cycles
//   row_idx      : current scan row
//   frame_start  : scan_en on row 7 (row index wrapping to 0)
module frame_controller #(
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic                 clk,
    input  logic                 aclr,
    frame_controller_if.slave    bus,
    output logic [127:0]         pixelReg,
    output logic                 scan_en,
    output logic [2:0]           row_idx,
    output logic                 frame_start
);

    localparam int unsigned PW   = $clog2(SCAN_DIV);
    localparam int unsigned IW   = 7;
    localparam logic [PW-1:0] LAST = PW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t          state;
    logic [127:0]    back_buf;
    logic            lg;
    logic            ack_q;
    logic [PW-1:0]   presc;
    logic            grant0;
    logic            grant1;
    logic [IW-1:0]   wr_idx;
    logic            wr_val;

    // Scan pacing: free-running, independent of the FSM.
    assign scan_en     = !aclr && (presc == LAST);
    assign frame_start = scan_en && (row_idx == 3'd7);

    always_ff @(posedge clk) begin
        if (aclr) begin
            presc   <= '0;
            row_idx <= '0;
        end else begin
            presc <= scan_en ? '0 : presc + PW'(1);
            if (scan_en) begin
                row_idx <= row_idx + 3'd1;
            end
        end
    end

    // Arbitration: only in IDLE, clr wins over writes, ties go to the
    // requester that was not granted last.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!aclr && state == IDLE && !bus.clr) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = lg;
                grant1 = !lg;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.swap_ack   = ack_q;

    assign wr_idx = grant1 ? {bus.req1_row, bus.req1_col} : {bus.req0_row, bus.req0_col};
    assign wr_val = grant1 ? bus.req1_val : bus.req0_val;

    // Commit FSM and frame store.
    always_ff @(posedge clk) begin
        if (aclr) begin
            state    <= IDLE;
            back_buf <= '0;
            pixelReg <= '0;
            lg       <= 1'b1;
            ack_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ack_q <= 1'b0;
                    if (bus.clr) begin
                        back_buf <= '0;
                    end else if (grant0 || grant1) begin
                        back_buf[wr_idx] <= wr_val;
                        lg               <= grant1;
                    end
                    if (bus.swap_req) begin
                        state <= PEND;
                    end
                end
                PEND: begin
                    ack_q <= 1'b0;
                    // Commit only on a frame boundary so the scanner never
                    // sees a partially updated image.
                    if (frame_start) begin
                        pixelReg <= back_buf;
                        ack_q    <= 1'b1;
                        state    <= ACK;
                    end
                end
                ACK: begin
                    ack_q <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    ack_q <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_controller.sv
// Self-checking bench for frame_controller with SCAN_DIV=4 and a
// cycle-count/array reference model.
module tb_frame_controller;

    localparam int D     = 4;
    localparam int FRAME = 8 * D;

    logic         clk = 1'b0;
    logic         aclr;
    logic [127:0] pixelReg;
    logic         scan_en;
    logic [2:0]   row_idx;
    logic         frame_start;

    always #5 clk = ~clk;

    frame_controller_if bus();

    frame_controller #(.SCAN_DIV(D)) dut (
        .clk         (clk),
        .aclr        (aclr),
        .bus         (bus),
        .pixelReg    (pixelReg),
        .scan_en     (scan_en),
        .row_idx     (row_idx),
        .frame_start (frame_start)
    );

    int           n_tests = 0;
    int           n_fail  = 0;
    int           k       = 0;      // cycles since reset release
    logic [127:0] m_back  = '0;
    logic [127:0] m_front = '0;
    logic         m_lg    = 1'b1;

    always @(posedge clk) k <= aclr ? 0 : k + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required=finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.req0_valid = 1'b0; bus.req0_row = '0; bus.req0_col = '0; bus.req0_val = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_row = '0; bus.req1_col = '0; bus.req1_val = 1'b0;
        bus.clr = 1'b0;
        bus.swap_req = 1'b0;
    endtask

    // Holds swap_req until swap_ack; lat = cycles from request to ack, -1 on timeout.
    task automatic do_commit(output int lat);
        bit done;
        done = 1'b0;
        lat = 0;
        bus.swap_req = 1'b1;
        while (!done) begin
            tick();
            lat++;
            if (bus.swap_ack === 1'b1) done = 1'b1;
            else if (lat > FRAME + 4) begin
                lat  = -1;
                done = 1'b1;
            end
        end
        bus.swap_req = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        idle_inputs();
        aclr = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            #2;
            n_tests++;
            if ({bus.req0_ready, bus.req1_ready, scan_en, frame_start} !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_hold: rdy0/rdy1/scan/fs=%b required=0000",
                         {bus.req0_ready, bus.req1_ready, scan_en, frame_start});
            end
        end
        tick();
        aclr = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        n_tests++;
        if (pixelReg !== 128'd0 || bus.swap_ack !== 1'b0 || row_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: pixelReg=%h ack=%b row=%0d required 0/0/0",
                     pixelReg, bus.swap_ack, row_idx);
        end
        // wait for the release edge so the bench sits in cycle 0 after reset
        tick();
    endtask

    task automatic test_scan;
        bit e_se, e_fs;
        int e_row;
        for (int i = 0; i < 70; i++) begin
            #2;
            e_se  = ((k % D) == D - 1);
            e_fs  = ((k % FRAME) == FRAME - 1);
            e_row = (k / D) % 8;
            n_tests++;
            if (scan_en !== e_se) begin
                n_fail++;
                $display("FAIL scan_en k=%0d: got %b required %b", k, scan_en, e_se);
            end
            n_tests++;
            if (frame_start !== e_fs) begin
                n_fail++;
                $display("FAIL frame_start k=%0d: got %b required %b", k, frame_start, e_fs);
            end
            n_tests++;
            if (row_idx !== 3'(e_row)) begin
                n_fail++;
                $display("FAIL row_idx k=%0d: got %0d required %0d", k, row_idx, e_row);
            end
            n_tests++;
            if (pixelReg !== m_front) begin
                n_fail++;
                $display("FAIL scan_pixel k=%0d: got %h required %h", k, pixelReg, m_front);
            end
            tick();
        end
    endtask

    // One IDLE cycle of arbitration with the model predicting the winner.
    task automatic arb_cycle(input bit v0, input bit v1, input bit c,
                             input logic [2:0] r0, input logic [3:0] c0, input logic x0,
                             input logic [2:0] r1, input logic [3:0] c1, input logic x1);
        int winner;
        bus.req0_valid = v0; bus.req0_row = r0; bus.req0_col = c0; bus.req0_val = x0;
        bus.req1_valid = v1; bus.req1_row = r1; bus.req1_col = c1; bus.req1_val = x1;
        bus.clr = c;
        winner = -1;
        if (!c) begin
            if (v0 && v1) winner = m_lg ? 0 : 1;
            else if (v0)  winner = 0;
            else if (v1)  winner = 1;
        end
        #2;
        n_tests++;
        if (bus.req0_ready !== (winner == 0) || bus.req1_ready !== (winner == 1)) begin
            n_fail++;
            $display("FAIL arbitration: v=%b%b clr=%b lg=%b ready=%b%b required winner %0d",
                     v0, v1, c, m_lg, bus.req0_ready, bus.req1_ready, winner);
        end
        if (c) m_back = '0;
        else if (winner == 0) begin
            m_back[int'(r0) * 16 + int'(c0)] = x0;
            m_lg = 1'b0;
        end else if (winner == 1) begin
            m_back[int'(r1) * 16 + int'(c1)] = x1;
            m_lg = 1'b1;
        end
        tick();
        idle_inputs();
    endtask

    task automatic check_commit(input string name);
        int lat;
        do_commit(lat);
        n_tests++;
        if (lat < 0 || pixelReg !== m_back) begin
            n_fail++;
            $display("FAIL %s: lat=%0d pixelReg=%h required %h", name, lat, pixelReg, m_back);
        end
        m_front = m_back;
        tick();
    endtask

    task automatic test_alternate;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (m_lg !== ((i % 2) == 0)) begin
                n_fail++;
                $display("FAIL alternate_order: model lg=%b at step %0d", m_lg, i);
            end
            arb_cycle(1'b1, 1'b1, 1'b0, 3'd0, 4'(i), 1'b1, 3'd1, 4'(i), 1'b1);
        end
        for (int i = 0; i < 3; i++) begin
            arb_cycle(1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0, 3'd6, 4'(i + 8), 1'b1);
        end
        check_commit("alternate_commit");
    endtask

    task automatic test_commit;
        int  lat;
        bit  seen;
        arb_cycle(1'b1, 1'b0, 1'b0, 3'd2, 4'd5, 1'b1, 3'd0, 4'd0, 1'b0);
        bus.swap_req = 1'b1;
        tick();
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req0_row = 3'd3;
        bus.req1_row = 3'd4;
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < FRAME + 4) begin
            #2;
            n_tests++;
            if ({bus.req0_ready, bus.req1_ready, bus.swap_ack} !== 3'b000) begin
                n_fail++;
                $display("FAIL pend_quiet: rdy0/rdy1/ack=%b required 000",
                         {bus.req0_ready, bus.req1_ready, bus.swap_ack});
            end
            seen = frame_start;
            tick();
            lat++;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL commit_timeout: no frame_start in %0d cycles required <= %0d", lat, FRAME);
        end
        #2;
        n_tests++;
        if (bus.swap_ack !== 1'b1 || pixelReg[37] !== 1'b1 || pixelReg !== m_back) begin
            n_fail++;
            $display("FAIL commit_37: ack=%b pix37=%b pixelReg=%h required ack=1 %h",
                     bus.swap_ack, pixelReg[37], pixelReg, m_back);
        end
        n_tests++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL ack_quiet: readies=%b required 00", {bus.req0_ready, bus.req1_ready});
        end
        m_front = m_back;
        idle_inputs();
        tick();
        #2;
        n_tests++;
        if (bus.swap_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_pulse_width: ack=%b required 0", bus.swap_ack);
        end
        tick();
    endtask

    task automatic test_clr_priority;
        arb_cycle(1'b1, 1'b0, 1'b1, 3'd4, 4'd9, 1'b1, 3'd0, 4'd0, 1'b0);
        arb_cycle(1'b1, 1'b0, 1'b0, 3'd4, 4'd9, 1'b1, 3'd0, 4'd0, 1'b0);
        check_commit("clr_then_write");
    endtask

    task automatic test_random;
        for (int round = 0; round < 3; round++) begin
            for (int i = 0; i < 30; i++) begin
                arb_cycle(1'($urandom_range(1)), 1'($urandom_range(1)),
                          ($urandom_range(7) == 0),
                          3'($urandom_range(7)), 4'($urandom_range(15)), 1'($urandom_range(1)),
                          3'($urandom_range(7)), 4'($urandom_range(15)), 1'($urandom_range(1)));
            end
            check_commit("random_commit");
        end
    endtask

    task automatic test_clr_swap;
        arb_cycle(1'b1, 1'b0, 1'b0, 3'd5, 4'd3, 1'b1, 3'd0, 4'd0, 1'b0);
        check_commit("pre_clr_image");
        bus.clr = 1'b1;
        m_back = '0;
        check_commit("clr_swap_blank");
    endtask

    task automatic test_swap_on_fs;
        int lat;
        int waited;
        arb_cycle(1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0, 3'd7, 4'd15, 1'b1);
        waited = 0;
        while ((k % FRAME) != FRAME - 1 && waited < 2 * FRAME) begin
            tick();
            waited++;
        end
        #1;
        n_tests++;
        if (frame_start !== 1'b1) begin
            n_fail++;
            $display("FAIL fs_align: frame_start=%b k=%0d required 1", frame_start, k);
        end
        do_commit(lat);
        n_tests++;
        if (lat !== FRAME + 1 || pixelReg !== m_back) begin
            n_fail++;
            $display("FAIL swap_on_fs: lat=%0d pixelReg=%h required lat=%0d %h",
                     lat, pixelReg, FRAME + 1, m_back);
        end
        m_front = m_back;
        tick();
    endtask

    task automatic test_reset_pend;
        int acks;
        bus.swap_req = 1'b1;
        tick();
        tick();
        aclr = 1'b1;
        bus.swap_req = 1'b0;
        tick();
        aclr = 1'b0;
        #2;
        n_tests++;
        if (pixelReg !== 128'd0 || row_idx !== 3'd0 || bus.swap_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pend: pixelReg=%h row=%0d ack=%b required 0/0/0",
                     pixelReg, row_idx, bus.swap_ack);
        end
        m_back  = '0;
        m_front = '0;
        m_lg    = 1'b1;
        tick();
        arb_cycle(1'b1, 1'b1, 1'b0, 3'd1, 4'd1, 1'b1, 3'd2, 4'd2, 1'b1);
        acks = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (bus.swap_ack === 1'b1) acks++;
            tick();
        end
        n_tests++;
        if (acks != 0 || pixelReg !== 128'd0) begin
            n_fail++;
            $display("FAIL reset_pend_noack: acks=%0d pixelReg=%h required 0/0", acks, pixelReg);
        end
        check_commit("post_reset_tie");
    endtask

    initial begin
        test_reset();
        test_scan();
        test_alternate();
        test_commit();
        test_clr_priority();
        test_random();
        test_clr_swap();
        test_swap_on_fs();
        test_reset_pend();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
